// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch requester and a
// data load/store requester. Data wins in IDLE; grants alternate at completion.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,

    input  logic                 d_read_req,
    input  logic                 d_write_req,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,

    output logic                 stall_i,
    output logic                 stall_d,
    output logic                 busy
);

    localparam int unsigned    CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        I_ACCESS = 2'd1,
        D_ACCESS = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 store, store_nx;
    logic                 mem_read_nx, mem_write_nx;
    logic [WORD_SIZE-1:0] mem_addr_nx, mem_wdata_nx;
    logic [WORD_SIZE-1:0] i_data_nx, d_rdata_nx;
    logic                 i_ready_nx, d_ready_nx;

    logic                 d_any;
    logic                 i_elig, d_elig;
    logic                 grant_i, grant_d;

    // A requester still holding its request during its ready cycle is not a new request.
    assign d_any  = d_read_req || d_write_req;
    assign i_elig = i_req && !i_ready;
    assign d_elig = d_any && !d_ready;

    assign stall_i = i_req && !i_ready;
    assign stall_d = d_any && !d_ready;
    assign busy    = (state != IDLE);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            store     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_data    <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            store     <= store_nx;
            mem_read  <= mem_read_nx;
            mem_write <= mem_write_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            i_data    <= i_data_nx;
            d_rdata   <= d_rdata_nx;
            i_ready   <= i_ready_nx;
            d_ready   <= d_ready_nx;
        end
    end

    // Next-state, grant and completion logic
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        store_nx     = store;
        mem_read_nx  = mem_read;
        mem_write_nx = mem_write;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        i_data_nx    = i_data;
        d_rdata_nx   = d_rdata;
        i_ready_nx   = 1'b0;
        d_ready_nx   = 1'b0;
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        case (state)
            IDLE: begin
                if (d_elig) begin
                    grant_d = 1'b1;
                end else if (i_elig) begin
                    grant_i = 1'b1;
                end
            end
            I_ACCESS: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    i_data_nx  = mem_rdata;
                    i_ready_nx = 1'b1;
                    if (d_elig) begin
                        grant_d = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            D_ACCESS: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    if (!store) begin
                        d_rdata_nx = mem_rdata;
                    end
                    d_ready_nx = 1'b1;
                    if (i_elig) begin
                        grant_i = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A simultaneous read+write request is performed as a store.
        if (grant_d) begin
            state_nx     = D_ACCESS;
            cnt_nx       = CNT_LOAD;
            store_nx     = d_write_req;
            mem_addr_nx  = d_addr;
            mem_read_nx  = !d_write_req;
            mem_write_nx = d_write_req;
            if (d_write_req) begin
                mem_wdata_nx = d_wdata;
            end
        end else if (grant_i) begin
            state_nx     = I_ACCESS;
            cnt_nx       = CNT_LOAD;
            store_nx     = 1'b0;
            mem_addr_nx  = i_addr;
            mem_read_nx  = 1'b1;
            mem_write_nx = 1'b0;
        end else if (state_nx == IDLE) begin
            cnt_nx       = '0;
            store_nx     = 1'b0;
            mem_read_nx  = 1'b0;
            mem_write_nx = 1'b0;
        end
    end

endmodule
